// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer: FETCH/WAIT/EXECUTE/HALTED.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN (adds fetch_timeout port).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  output logic [31:0] pc_of_instruction,
  output logic [31:0] pc_plus_4,
  input  logic        exec_done,
  input  logic [1:0]  pc_update,
  input  logic [31:0] pc_offset,
  input  logic [31:0] jalr_base,
  output logic        halted,
  output logic        misaligned_trap
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetch_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_EXECUTE,
    ST_HALTED
  } state_t;

  localparam logic [1:0] UPD_NEXT   = 2'd0;
  localparam logic [1:0] UPD_BRANCH = 2'd1;
  localparam logic [1:0] UPD_JALR   = 2'd2;

  // A non-positive watchdog limit has no meaning; the branch is intentionally empty.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_limit_invalid
  end

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instruction_q, instruction_d;
  logic        fetch_req_q, fetch_req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        trap_q, trap_d;
  logic [31:0] next_pc;
  logic        fetch_accept;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    next_pc = pc_q + 32'd4;
    case (pc_update)
      UPD_NEXT:   next_pc = pc_q + 32'd4;
      UPD_BRANCH: next_pc = pc_q + pc_offset;
      UPD_JALR:   next_pc = (jalr_base + pc_offset) & ~32'd1;
      default:    next_pc = pc_q;
    endcase
  end

  // fetch_req is still low in the first FETCH cycle after reset, so an ack there is not ours.
  assign fetch_accept = fetch_ack && fetch_req_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    fetch_req_d   = fetch_req_q;
    valid_d       = valid_q;
    halted_d      = halted_q;
    trap_d        = trap_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
`endif
    case (state_q)
      ST_FETCH, ST_WAIT: begin
        fetch_req_d = 1'b1;
        if (fetch_accept) begin
          instruction_d = fetch_data;
          fetch_req_d   = 1'b0;
          valid_d       = 1'b1;
          state_d       = ST_EXECUTE;
        end else begin
          state_d = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
          if (wait_cnt_q == TIMEOUT_LIMIT) begin
            fetch_req_d = 1'b0;
            halted_d    = 1'b1;
            timeout_d   = 1'b1;
            state_d     = ST_HALTED;
          end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
          end
`endif
        end
      end
      ST_EXECUTE: begin
        if (exec_done) begin
          valid_d = 1'b0;
          if (pc_update == 2'd3) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else if (next_pc[1:0] != 2'b00) begin
            trap_d   = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            pc_d        = next_pc;
            fetch_req_d = 1'b1;
            state_d     = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_d  = 32'd0;
`endif
          end
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_VECTOR;
      instruction_q <= 32'd0;
      fetch_req_q   <= 1'b0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      trap_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q    <= 32'd0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      fetch_req_q   <= fetch_req_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
      trap_q        <= trap_d;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign fetch_req         = fetch_req_q;
  assign fetch_addr        = pc_q;
  assign instruction       = instruction_q;
  assign instruction_valid = valid_q;
  assign pc_of_instruction = pc_q;
  assign pc_plus_4         = pc_q + 32'd4;
  assign halted            = halted_q;
  assign misaligned_trap   = trap_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch/execute vectors, expected
// executions and halts are queued by the stimulus and popped by a monitor.
module tb_pc_fetch_unit;

   localparam logic [1:0] UPD_NEXT   = 2'd0;
   localparam logic [1:0] UPD_BRANCH = 2'd1;
   localparam logic [1:0] UPD_JALR   = 2'd2;
   localparam logic [1:0] UPD_HALT   = 2'd3;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack = 1'b0;
   logic [31:0] fetch_data = 32'd0;
   logic [31:0] instruction;
   logic        instruction_valid;
   logic [31:0] pc_of_instruction;
   logic [31:0] pc_plus_4;
   logic        exec_done = 1'b0;
   logic [1:0]  pc_update = 2'd0;
   logic [31:0] pc_offset = 32'd0;
   logic [31:0] jalr_base = 32'd0;
   logic        halted;
   logic        misaligned_trap;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_timeout;
`endif

   typedef struct {
      logic        isHalt;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        trap;
   } expItem_t;

   expItem_t expQueue[$];
   int vectors = 0;
   int miscompares = 0;

   pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .fetch_req(fetch_req),
      .fetch_addr(fetch_addr),
      .fetch_ack(fetch_ack),
      .fetch_data(fetch_data),
      .instruction(instruction),
      .instruction_valid(instruction_valid),
      .pc_of_instruction(pc_of_instruction),
      .pc_plus_4(pc_plus_4),
      .exec_done(exec_done),
      .pc_update(pc_update),
      .pc_offset(pc_offset),
      .jalr_base(jalr_base),
      .halted(halted),
      .misaligned_trap(misaligned_trap)
`ifdef FETCH_TIMEOUT_EN
      ,
      .fetch_timeout(fetch_timeout)
`endif
   );

   // Free-running 10-time-unit clock
   always #5 clock = ~clock;

   // Hard stop in case a stimulus wait ever runs away
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: whenever the DUT enters EXECUTE or HALTED, pop the oldest expectation
   logic prevValid = 1'b0;
   logic prevHalted = 1'b0;
   always @(negedge clock) begin
      expItem_t e;
      if (instruction_valid === 1'b1 && prevValid !== 1'b1) begin
         if (expQueue.size() == 0) begin
            checkOutput("unexpectedExecute", 32'd1, 32'd0);
         end else begin
            e = expQueue.pop_front();
            checkOutput("execKind", {31'd0, e.isHalt}, 32'd0);
            checkOutput("execPc", pc_of_instruction, e.pc);
            checkOutput("execInstr", instruction, e.instr);
            checkOutput("execPcPlus4", pc_plus_4, e.pc + 32'd4);
         end
      end
      if (halted === 1'b1 && prevHalted !== 1'b1) begin
         if (expQueue.size() == 0) begin
            checkOutput("unexpectedHalt", 32'd1, 32'd0);
         end else begin
            e = expQueue.pop_front();
            checkOutput("haltKind", {31'd0, e.isHalt}, 32'd1);
            checkOutput("haltPc", fetch_addr, e.pc);
            checkOutput("haltTrap", {31'd0, misaligned_trap}, {31'd0, e.trap});
            checkOutput("haltReq", {31'd0, fetch_req}, 32'd0);
         end
      end
      prevValid  <= instruction_valid;
      prevHalted <= halted;
   end

   task automatic checkResetState();
      checkOutput("rstReq", {31'd0, fetch_req}, 32'd0);
      checkOutput("rstAddr", fetch_addr, 32'h0000_0000);
      checkOutput("rstInstr", instruction, 32'd0);
      checkOutput("rstValid", {31'd0, instruction_valid}, 32'd0);
      checkOutput("rstHalted", {31'd0, halted}, 32'd0);
      checkOutput("rstTrap", {31'd0, misaligned_trap}, 32'd0);
   endtask

   task automatic resetDut();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checkResetState();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Bounded wait for the DUT to raise fetch_req
   task automatic waitReq();
      int n = 0;
      while (fetch_req !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      checkOutput("fetchReqSeen", {31'd0, fetch_req}, 32'd1);
   endtask

   // One full fetch (with optional stall) followed by one execute command
   task automatic applyStimulus(input logic [31:0] expPc, input logic [31:0] word, input int stall,
                                input logic [1:0] upd, input logic [31:0] off, input logic [31:0] base,
                                input logic expectHalt, input logic expTrap);
      waitReq();
      checkOutput("fetchAddr", fetch_addr, expPc);
      expQueue.push_back('{1'b0, expPc, word, 1'b0});
      for (int i = 0; i < stall; i++) begin
         @(negedge clock);
         checkOutput("stallReq", {31'd0, fetch_req}, 32'd1);
         checkOutput("stallAddr", fetch_addr, expPc);
      end
      fetch_ack  = 1'b1;
      fetch_data = word;
      @(negedge clock);
      fetch_ack  = 1'b0;
      fetch_data = 32'hDEAD_BEEF;
      checkOutput("validHigh", {31'd0, instruction_valid}, 32'd1);
      checkOutput("execReqLow", {31'd0, fetch_req}, 32'd0);
      fetch_ack  = 1'b1;
      fetch_data = 32'hBAD0_0BAD;
      @(negedge clock);
      fetch_ack  = 1'b0;
      checkOutput("ackIgnored", instruction, word);
      checkOutput("pcStable", pc_of_instruction, expPc);
      if (expectHalt) expQueue.push_back('{1'b1, expPc, 32'd0, expTrap});
      exec_done = 1'b1;
      pc_update = upd;
      pc_offset = off;
      jalr_base = base;
      @(negedge clock);
      exec_done = 1'b0;
      checkOutput("validDropped", {31'd0, instruction_valid}, 32'd0);
   endtask

   initial begin
      $display("[TB] pc_fetch_unit bench starting");
      resetDut();

      applyStimulus(32'h0000_0000, 32'h0000_0013, 0, UPD_BRANCH, 32'h0000_0100, 32'd0, 1'b0, 1'b0);
      applyStimulus(32'h0000_0100, 32'h1111_1111, 0, UPD_NEXT,   32'd0,         32'd0, 1'b0, 1'b0);
      applyStimulus(32'h0000_0104, 32'h2222_2222, 2, UPD_BRANCH, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0);
      applyStimulus(32'h0000_00FC, 32'h3333_3333, 0, UPD_JALR,   32'h0000_0003, 32'h0000_2001, 1'b0, 1'b0);
      applyStimulus(32'h0000_2004, 32'h4444_4444, 0, UPD_JALR,   32'd0,         32'h0000_2001, 1'b0, 1'b0);
      applyStimulus(32'h0000_2000, 32'h5555_5555, 5, UPD_JALR,   32'd0,         32'hFFFF_FFFC, 1'b0, 1'b0);
      applyStimulus(32'hFFFF_FFFC, 32'h6666_6666, 0, UPD_NEXT,   32'd0,         32'd0, 1'b0, 1'b0);
      applyStimulus(32'h0000_0000, 32'h7777_7777, 0, UPD_BRANCH, 32'h0000_0010, 32'd0, 1'b0, 1'b0);
      applyStimulus(32'h0000_0010, 32'h8888_8888, 0, UPD_BRANCH, 32'h0000_0006, 32'd0, 1'b1, 1'b1);

      // After a misaligned target the core must stay frozen even if execute keeps pulsing
      checkOutput("trapPcHold", fetch_addr, 32'h0000_0010);
      exec_done = 1'b1;
      pc_update = UPD_NEXT;
      @(negedge clock);
      exec_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("haltedNoReq", {31'd0, fetch_req}, 32'd0);
         checkOutput("haltedStays", {31'd0, halted}, 32'd1);
      end
      checkOutput("trapSticky", {31'd0, misaligned_trap}, 32'd1);
      checkOutput("trapPcFinal", fetch_addr, 32'h0000_0010);

      resetDut();
      applyStimulus(32'h0000_0000, 32'h0010_0073, 0, UPD_HALT, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("haltNoTrap", {31'd0, misaligned_trap}, 32'd0);
      checkOutput("haltPcHeld", fetch_addr, 32'h0000_0000);

      // Reset while waiting on a fetch from a non-reset PC
      resetDut();
      applyStimulus(32'h0000_0000, 32'h9999_9999, 0, UPD_NEXT, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("waitReq", {31'd0, fetch_req}, 32'd1);
      checkOutput("waitAddr", fetch_addr, 32'h0000_0004);
      reset_n = 1'b0;
      #1;
      checkResetState();
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(32'h0000_0000, 32'hAAAA_AAAA, 1, UPD_BRANCH, 32'h0000_0040, 32'd0, 1'b0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
      expQueue.push_back('{1'b1, 32'h0000_0040, 32'd0, 1'b0});
      repeat (15) @(negedge clock);
      checkOutput("preTimeoutHalted", {31'd0, halted}, 32'd0);
      checkOutput("preTimeoutFlag", {31'd0, fetch_timeout}, 32'd0);
      @(negedge clock);
      checkOutput("timeoutHalted", {31'd0, halted}, 32'd1);
      checkOutput("timeoutFlag", {31'd0, fetch_timeout}, 32'd1);
`else
      repeat (100) @(negedge clock);
      checkOutput("longWaitReq", {31'd0, fetch_req}, 32'd1);
      checkOutput("longWaitAddr", fetch_addr, 32'h0000_0040);
      checkOutput("longWaitHalted", {31'd0, halted}, 32'd0);
`endif

      @(negedge clock);
      checkOutput("scoreboardDrained", expQueue.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
